// File: rtl/multi_filt_psum_engine.sv
// Multi-filter MAC/psum engine: one IF value reused across filters, psum bank, drain.
// Optional PSUM_SAT_EN: saturating accumulation plus sticky sat_flag output.
module multi_filt_psum_engine #(
   parameter int DATA_W     = 8,
   parameter int WGT_W      = 8,
   parameter int ACC_W      = 20,
   parameter int NUM_FILT   = 4,
   parameter int FILT_IDX_W = 2,
   parameter int LEN_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      filt_len,
   input  logic [FILT_IDX_W:0]   num_filt,
   input  logic                  psum_in_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     if_val,
   input  logic [WGT_W-1:0]      wgt_val,
   input  logic                  psum_in_valid,
   output logic                  psum_in_ready,
   input  logic [ACC_W-1:0]      psum_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_data,
   output logic [FILT_IDX_W-1:0] out_filt,
   output logic                  busy,
   output logic                  done
`ifdef PSUM_SAT_EN
   ,
   output logic                  sat_flag
`endif
);

   localparam int PROD_W = DATA_W + WGT_W;
   localparam logic [FILT_IDX_W:0] NF_MAX = (FILT_IDX_W+1)'(NUM_FILT);

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      FLUSH,
      PSUM,
      DRAIN
   } state_t;

   state_t state, state_n;

   logic [LEN_W-1:0]      cfg_len;
   logic [FILT_IDX_W:0]   cfg_nf;
   logic                  cfg_psum;
   logic [LEN_W-1:0]      k;
   logic [FILT_IDX_W-1:0] f;
   logic [FILT_IDX_W-1:0] prod_f;
   logic [ACC_W-1:0]      prod;
   logic                  prod_v;
   logic [ACC_W-1:0]      bank [NUM_FILT];

   logic                  start_ok;
   logic                  in_fire;
   logic                  ps_fire;
   logic                  out_fire;
   logic                  last_f;
   logic                  last_k;
   logic [PROD_W-1:0]     prod_full;
   logic                  add_en;
   logic [FILT_IDX_W-1:0] add_idx;
   logic [ACC_W-1:0]      add_b;
   logic [ACC_W-1:0]      add_res;

   assign start_ok = (state == IDLE) && start
                   && (num_filt != '0) && (num_filt <= NF_MAX);

   assign in_ready      = (state == ACCUM);
   assign psum_in_ready = (state == PSUM);
   assign out_valid     = (state == DRAIN);
   assign busy          = (state != IDLE);

   assign in_fire  = in_valid && in_ready;
   assign ps_fire  = psum_in_valid && psum_in_ready;
   assign out_fire = out_valid && out_ready;

   assign last_f = ({1'b0, f} == cfg_nf - 1'b1);
   assign last_k = (k == cfg_len - 1'b1);

   assign out_data = out_valid ? bank[f] : '0;
   assign out_filt = out_valid ? f : '0;

   assign prod_full = PROD_W'(if_val) * PROD_W'(wgt_val);

   // Registered products and psum accepts never overlap, so one adder serves both.
   assign add_en  = prod_v || ps_fire;
   assign add_idx = prod_v ? prod_f : f;
   assign add_b   = prod_v ? prod : psum_in;

`ifdef PSUM_SAT_EN
   logic [ACC_W:0] sum_w;
   assign sum_w   = {1'b0, bank[add_idx]} + {1'b0, add_b};
   assign add_res = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
`else
   assign add_res = bank[add_idx] + add_b;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start_ok) begin
               if (filt_len != '0) state_n = ACCUM;
               else if (psum_in_en) state_n = PSUM;
               else state_n = DRAIN;
            end
         end
         ACCUM: begin
            if (in_fire && last_f && last_k) state_n = FLUSH;
         end
         FLUSH: begin
            state_n = cfg_psum ? PSUM : DRAIN;
         end
         PSUM: begin
            if (ps_fire && last_f) state_n = DRAIN;
         end
         DRAIN: begin
            if (out_fire && last_f) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_len  <= '0;
         cfg_nf   <= '0;
         cfg_psum <= 1'b0;
         k        <= '0;
         f        <= '0;
         prod     <= '0;
         prod_f   <= '0;
         prod_v   <= 1'b0;
         done     <= 1'b0;
         for (int i = 0; i < NUM_FILT; i++) bank[i] <= '0;
`ifdef PSUM_SAT_EN
         sat_flag <= 1'b0;
`endif
      end else begin
         done   <= 1'b0;
         prod_v <= in_fire;
         if (in_fire) begin
            prod   <= ACC_W'(prod_full);
            prod_f <= f;
            if (last_f) begin
               f <= '0;
               k <= last_k ? '0 : k + 1'b1;
            end else begin
               f <= f + 1'b1;
            end
         end
         if (add_en) bank[add_idx] <= add_res;
`ifdef PSUM_SAT_EN
         if (add_en && sum_w[ACC_W]) sat_flag <= 1'b1;
`endif
         if (ps_fire || out_fire) f <= last_f ? '0 : f + 1'b1;
         if (out_fire && last_f) done <= 1'b1;
         if (start_ok) begin
            cfg_len  <= filt_len;
            cfg_nf   <= num_filt;
            cfg_psum <= psum_in_en;
            f        <= '0;
            k        <= '0;
            for (int i = 0; i < NUM_FILT; i++) bank[i] <= '0;
`ifdef PSUM_SAT_EN
            sat_flag <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_multi_filt_psum_engine.sv
// Randomised bench for multi_filt_psum_engine against a sum-of-products model.
// Build with +define+PSUM_SAT_EN to exercise the saturating variant.
module tb_multi_filt_psum_engine;

   localparam int ACC_W = 16;
   localparam longint ACC_MAX = 65535;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  filt_len;
   logic [2:0]  num_filt;
   logic        psum_in_en;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  if_val;
   logic [7:0]  wgt_val;
   logic        psum_in_valid;
   logic        psum_in_ready;
   logic [15:0] psum_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [1:0]  out_filt;
   logic        busy;
   logic        done;
`ifdef PSUM_SAT_EN
   logic        sat_flag;
`endif

   multi_filt_psum_engine #(
      .DATA_W(8), .WGT_W(8), .ACC_W(ACC_W),
      .NUM_FILT(4), .FILT_IDX_W(2), .LEN_W(5)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .filt_len(filt_len), .num_filt(num_filt), .psum_in_en(psum_in_en),
      .in_valid(in_valid), .in_ready(in_ready),
      .if_val(if_val), .wgt_val(wgt_val),
      .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
      .psum_in(psum_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_filt(out_filt),
      .busy(busy), .done(done)
`ifdef PSUM_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   int unsigned ifs [32];
   int unsigned ws  [32][4];
   int unsigned ps  [4];

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint raw_total(int f, int len, bit pen);
      longint t = 0;
      for (int k = 0; k < len; k++) t += longint'(ifs[k]) * longint'(ws[k][f]);
      if (pen) t += longint'(ps[f]);
      return t;
   endfunction

   function automatic longint model(int f, int len, bit pen);
      longint t = raw_total(f, len, pen);
`ifdef PSUM_SAT_EN
      return (t > ACC_MAX) ? ACC_MAX : t;
`else
      return t % (ACC_MAX + 1);
`endif
   endfunction

   function automatic bit model_sat(int nf, int len, bit pen);
      bit s = 1'b0;
      for (int f = 0; f < nf; f++) if (raw_total(f, len, pen) > ACC_MAX) s = 1'b1;
      return s;
   endfunction

   task automatic send_pair(input int a, input int b, input bit tog, output int at);
      at = -1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (tog && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            if_val   = 8'(a);
            wgt_val  = 8'(b);
            if (in_ready) begin
               at = cyc;
               chk("psum_rdy_in_accum", psum_in_ready, 0);
               @(posedge clk);
               return;
            end
         end
      end
      chk("pair_timeout", 0, 1);
   endtask

   task automatic send_psum(input int v, input bit tog);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (tog && $urandom_range(0, 2) == 0) begin
            psum_in_valid = 1'b0;
         end else begin
            psum_in_valid = 1'b1;
            psum_in       = 16'(v);
            if (psum_in_ready) begin
               @(posedge clk);
               return;
            end
         end
      end
      chk("psum_timeout", 0, 1);
   endtask

   task automatic start_job(input int nf, input int len, input bit pen);
      @(negedge clk);
      start      = 1'b1;
      num_filt   = 3'(nf);
      filt_len   = 5'(len);
      psum_in_en = pen;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_job(input int nf, input int len, input bit pen,
                          input bit tog, input bit stall, input bit inject);
      int last_cyc = -1;
      int first_ov = -1;
      int idx = 0;
      int stall_cnt = 0;
      int at;
      bit r;
      start_job(nf, len, pen);
      chk("busy_after_start", busy, 1);
`ifdef PSUM_SAT_EN
      chk("sat_clear_on_start", sat_flag, 0);
`endif
      for (int k = 0; k < len; k++) begin
         for (int f = 0; f < nf; f++) begin
            if (inject && (k * nf + f) == 1) begin
               @(negedge clk);
               in_valid   = 1'b0;
               start      = 1'b1;
               num_filt   = 3'd1;
               filt_len   = 5'd0;
               psum_in_en = ~pen;
               @(negedge clk);
               start = 1'b0;
               chk("busy_on_restart", busy, 1);
            end
            send_pair(int'(ifs[k]), int'(ws[k][f]), tog, at);
            last_cyc = at;
         end
      end
      if (pen) for (int f = 0; f < nf; f++) send_psum(int'(ps[f]), tog);
      for (int n = 0; n < 300 && idx < nf; n++) begin
         @(negedge clk);
         in_valid      = 1'b0;
         psum_in_valid = 1'b0;
         r = ($urandom_range(0, 3) != 0);
         if (out_valid) begin
            if (first_ov < 0) first_ov = cyc;
            if (stall && stall_cnt < 5) begin
               r = 1'b0;
               stall_cnt++;
            end
            chk("out_data", out_data, model(idx, len, pen));
            chk("out_filt", out_filt, idx);
            if (r) idx++;
         end
         out_ready = r;
      end
      chk("drain_count", idx, nf);
      if (!pen && len > 0) chk("first_out_latency", first_ov - last_cyc, 2);
      @(negedge clk);
      out_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("busy_idle", busy, 0);
`ifdef PSUM_SAT_EN
      chk("sat_flag", sat_flag, model_sat(nf, len, pen));
`endif
      @(negedge clk);
      chk("done_one_cycle", done, 0);
   endtask

   task automatic try_bad(input int nf);
      start_job(nf, 3, 1'b0);
      chk("bad_start_busy", busy, 0);
      @(negedge clk);
      chk("bad_start_busy_later", busy, 0);
   endtask

   task automatic load_basic();
      for (int k = 0; k < 3; k++) begin
         ifs[k]   = k + 1;
         ws[k][0] = 1;
      end
      ws[0][1] = 2;
      ws[1][1] = 0;
      ws[2][1] = 4;
   endtask

   initial begin
      int at;
      int nf, len;
      bit pen;
      rst = 1'b0;
      start = 1'b0;
      filt_len = '0;
      num_filt = '0;
      psum_in_en = 1'b0;
      in_valid = 1'b0;
      if_val = '0;
      wgt_val = '0;
      psum_in_valid = 1'b0;
      psum_in = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_psum_ready", psum_in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_done", done, 0);
      rst = 1'b1;

      load_basic();
      run_job(2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
      ps[0] = 100;
      ps[1] = 200;
      run_job(2, 3, 1'b1, 1'b0, 1'b0, 1'b0);
      run_job(2, 3, 1'b0, 1'b1, 1'b1, 1'b0);
      run_job(4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      try_bad(0);
      try_bad(5);
      run_job(2, 3, 1'b0, 1'b0, 1'b0, 1'b1);

      ifs[0] = 255;
      ifs[1] = 255;
      ws[0][0] = 255;
      ws[1][0] = 255;
      run_job(1, 2, 1'b0, 1'b0, 1'b0, 1'b0);

      load_basic();
      start_job(1, 3, 1'b0);
      send_pair(int'(ifs[0]), int'(ws[0][0]), 1'b0, at);
      send_pair(int'(ifs[1]), int'(ws[1][0]), 1'b0, at);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_done", done, 0);
      @(negedge clk);
      rst = 1'b1;
      run_job(1, 3, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int j = 0; j < 10; j++) begin
         nf  = $urandom_range(1, 4);
         len = $urandom_range(0, 6);
         pen = 1'($urandom_range(0, 1));
         for (int k = 0; k < len; k++) begin
            ifs[k] = $urandom_range(0, 255);
            for (int f = 0; f < 4; f++) ws[k][f] = $urandom_range(0, 255);
         end
         for (int f = 0; f < 4; f++) ps[f] = $urandom_range(0, 65535);
         run_job(nf, len, pen, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/multi_filt_psum_engine.md
Name: multi_filt_psum_engine

Overview:
- Parametrised multi-filter MAC/psum engine for the convolution PE.
- Consumes a stream of (IF, weight) pairs ordered IF-position-major / filter-minor, one IF value reused across all active filters.
- Accumulates one partial sum per filter in an internal psum bank and optionally adds an incoming psum per filter.
- Drains results through a valid/ready output toward the output buffer.

Parameters:
- DATA_W, 8, IF element width (unsigned)
- WGT_W, 8, filter weight width (unsigned)
- ACC_W, 20, accumulator/psum width; must be >= DATA_W+WGT_W
- NUM_FILT, 4, psum bank depth (max concurrent filters)
- FILT_IDX_W, 2, index width; must be >= clog2(NUM_FILT), minimum 1
- LEN_W, 5, filter-length field width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job start pulse
- filt_len  in  LEN_W  elements per filter; sampled on accepted start
- num_filt  in  FILT_IDX_W+1  active filters, 1..NUM_FILT; sampled on accepted start
- psum_in_en  in  1  add external psum per filter; sampled on accepted start
- in_valid  in  1  pair valid
- in_ready  out  1  pair accepted when in_valid && in_ready
- if_val  in  DATA_W  IF operand
- wgt_val  in  WGT_W  weight operand
- psum_in_valid  in  1  external psum valid
- psum_in_ready  out  1  external psum handshake
- psum_in  in  ACC_W  external psum, filter order 0..num_filt-1
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  ACC_W  accumulated psum
- out_filt  out  FILT_IDX_W  filter index of out_data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last result accepted

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready, psum_in_ready, out_valid, busy, done = 0; out_data, out_filt = 0; bank, counters, product register cleared.
- States: IDLE, ACCUM, FLUSH, PSUM, DRAIN.
- IDLE:
  - start accepted only if 1 <= num_filt <= NUM_FILT; otherwise ignored (stays IDLE, busy=0).
  - On accept: bank cleared to 0, f=k=0, config latched.
  - Next state: ACCUM if filt_len != 0, else PSUM if psum_in_en, else DRAIN.
  - start in any other state is ignored.
- ACCUM:
  - in_ready=1.
  - Each accepted pair: product = if_val*wgt_val (full DATA_W+WGT_W bits, zero-extended to ACC_W) registered with its f index; one cycle later acc[f] += product.
  - f wraps num_filt-1 -> 0, incrementing k.
  - The pair with k=filt_len-1 and f=num_filt-1 is the last; in_ready drops the following cycle and the state moves to FLUSH.
- FLUSH: one cycle; the last product is written to the bank. Next state: PSUM if psum_in_en, else DRAIN.
- PSUM:
  - psum_in_ready=1; each accepted psum_in adds to acc[f], f = 0..num_filt-1.
  - After the last accept: DRAIN.
  - Adder result is forwarded so back-to-back accepts are correct.
- DRAIN:
  - out_valid=1, out_data=acc[f], out_filt=f; holds stable while out_ready=0.
  - f advances on handshake.
  - After f=num_filt-1 handshake: done=1 for one cycle, state IDLE.
- Latency: first out_valid appears 2 cycles after the last accepted pair when psum_in_en=0 (1 cycle in FLUSH, then DRAIN).
- Throughput: one pair per cycle, no bubbles, while in_valid=1.
- Arithmetic: unsigned. Without the optional feature, additions wrap modulo 2^ACC_W.
- rst asserted mid-job: immediate abort, all state returns to reset values; no done pulse.

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined: every accumulation (ACCUM and PSUM adds) saturates at 2^ACC_W-1. Output sat_flag (1 bit, reset 0) goes high and stays sticky when any add saturates; it clears on the next accepted start.
- Undefined: adds wrap modulo 2^ACC_W and the sat_flag port is absent.

Test Plan:
- Basic job: num_filt=2, filt_len=3, psum_in_en=0, IF={1,2,3}, W0={1,1,1}, W1={2,0,4}, pairs fed back-to-back with out_ready=1 -> out (filt0=6), (filt1=14); done pulses once; first out_valid 2 cycles after the last pair.
- External psum: same job with psum_in_en=1 and psum_in={100,200} -> outputs 106, 214; psum_in_ready low outside PSUM.
- Backpressure: hold out_ready=0 for 5 cycles in DRAIN and toggle in_valid during ACCUM -> out_data/out_filt stable while stalled; totals unchanged; no pair lost or duplicated.
- Corner configs:
  - filt_len=0, psum_in_en=0, num_filt=4 -> four outputs of 0.
  - num_filt=0 or 5 -> start ignored, busy stays 0.
  - start while busy -> ignored.
- Overflow: ACC_W=16, num_filt=1, filt_len=2, pairs 255*255 twice -> 0xFC02 when PSUM_SAT_EN is undefined; 0xFFFF with sat_flag=1 when defined.
- Reset mid-job: drop rst after 2 pairs of a 3-element job -> all outputs 0 immediately; a new full job then yields correct sums with no residue from the aborted job.
